// File: rtl/tb_hwpe_stream_transmitter.sv
// HWPE-Stream traffic source: emits a programmed number of incrementing data beats with
// LFSR-driven valid bubbles so every run is cycle-reproducible from the seed.
module tb_hwpe_stream_transmitter #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [7:0]            STALL_THRESH = 8'd0,
  parameter logic [15:0]           LFSR_SEED    = 16'hACE1,
  parameter logic [DATA_WIDTH-1:0] DATA_BASE    = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      start_i,
  input  logic [15:0]               len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [15:0]               count_o,
  output logic                      push_valid_o,
  output logic [DATA_WIDTH-1:0]     push_data_o,
  output logic [DATA_WIDTH/8-1:0]   push_strb_o,
  input  logic                      push_ready_i
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [15:0]           lfsr_q, lfsr_d;

  logic        handshake;
  logic        offer;
  logic [15:0] lfsr_next;
  logic [15:0] count_inc;

  assign handshake = valid_q & push_ready_i;
  assign offer     = (lfsr_q[7:0] >= STALL_THRESH);
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign count_inc = count_q + 16'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q;
    lfsr_d  = lfsr_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          len_d   = len_i;
          count_d = 16'd0;
          data_d  = DATA_BASE;
          valid_d = 1'b0;
          state_d = (len_i == 16'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (!valid_q) begin
          // The LFSR keeps running during enable gaps so bubble timing stays seed-determined
          lfsr_d = lfsr_next;
          if (enable_i && offer) valid_d = 1'b1;
        end else if (handshake) begin
          lfsr_d  = lfsr_next;
          count_d = count_inc;
          data_d  = data_q + DATA_WIDTH'(1);
          if (count_inc == len_q) begin
            valid_d = 1'b0;
            state_d = StDone;
          end else begin
            valid_d = enable_i && offer;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      len_q   <= 16'd0;
      count_q <= 16'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign busy_o       = (state_q == StRun);
  assign done_o       = (state_q == StDone);
  assign count_o      = count_q;
  assign push_valid_o = valid_q;
  assign push_data_o  = data_q;
  assign push_strb_o  = {(DATA_WIDTH/8){valid_q}};

endmodule

// File: tb/tb_tb_hwpe_stream_transmitter.sv
// Scoreboard bench for the stream transmitter: one instance without stalls for directed and
// random-handshake bursts, one with STALL_THRESH=128 checked against a bubble model.
module tb_tb_hwpe_stream_transmitter;

  localparam logic [15:0] Seed = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_en = 1'b1, a_start = 1'b0, a_ready = 1'b0;
  logic [15:0] a_len = 16'd0;
  logic        a_busy, a_done, a_valid;
  logic [15:0] a_cnt;
  logic [31:0] a_data;
  logic [3:0]  a_strb;

  logic        b_en = 1'b1, b_start = 1'b0, b_ready = 1'b1;
  logic [15:0] b_len = 16'd0;
  logic        b_busy, b_done, b_valid;
  logic [15:0] b_cnt;
  logic [31:0] b_data;
  logic [3:0]  b_strb;

  tb_hwpe_stream_transmitter #(
    .DATA_WIDTH(32), .STALL_THRESH(8'd0), .LFSR_SEED(Seed), .DATA_BASE(32'd0)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(a_en), .start_i(a_start), .len_i(a_len),
    .busy_o(a_busy), .done_o(a_done), .count_o(a_cnt), .push_valid_o(a_valid),
    .push_data_o(a_data), .push_strb_o(a_strb), .push_ready_i(a_ready)
  );

  tb_hwpe_stream_transmitter #(
    .DATA_WIDTH(32), .STALL_THRESH(8'd128), .LFSR_SEED(Seed), .DATA_BASE(32'd0)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(b_en), .start_i(b_start), .len_i(b_len),
    .busy_o(b_busy), .done_o(b_done), .count_o(b_cnt), .push_valid_o(b_valid),
    .push_data_o(b_data), .push_strb_o(b_strb), .push_ready_i(b_ready)
  );

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks the hold rule under backpressure
  logic        pv_a = 1'b0, pr_a = 1'b0, prst = 1'b1;
  logic [31:0] pd_a = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (!prst && pv_a && !pr_a) begin
        check("hold_valid", a_valid, 32'd1);
        check("hold_data", a_data, pd_a);
      end
      if (a_valid && a_ready) begin
        if (exp_q_a.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL a_extra_beat: got beat data %0h, expected no beat", a_data);
        end else begin
          check("a_data", a_data, exp_q_a.pop_front());
          check("a_strb", a_strb, 32'hF);
        end
      end
      if (b_valid && b_ready) begin
        if (exp_q_b.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL b_extra_beat: got beat data %0h, expected no beat", b_data);
        end else begin
          check("b_data", b_data, exp_q_b.pop_front());
        end
      end
    end
    pv_a <= a_valid;
    pr_a <= a_ready;
    pd_a <= a_data;
    prst <= rst;
  end

  task automatic start_a(input int len);
    for (int i = 0; i < len; i++) exp_q_a.push_back(32'(i));
    a_start = 1'b1;
    a_len   = 16'(len);
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input int len);
    int n = 0;
    while (!a_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("a_done", a_done, 32'd1);
    check("a_count", a_cnt, 32'(len));
    check("a_busy", a_busy, 32'd0);
    check("a_q_empty", exp_q_a.size(), 32'd0);
  endtask

  task automatic count_hs_a(input int target, output int hs);
    int n = 0;
    hs = 0;
    while (hs < target && n < 100) begin
      @(negedge clk);
      n++;
      if (a_valid && a_ready) hs++;
    end
  endtask

  // Model: every RUN cycle makes one decision on a fresh LFSR value; valid follows one cycle later
  task automatic run_b();
    bit          exp_v[$];
    logic [15:0] l = Seed;
    int          ones = 0;
    int          nv = 0;
    int          ncyc = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_v.push_back(1'b0);
    while (ones < 1000) begin
      exp_v.push_back(l[7:0] >= 8'd128);
      if (l[7:0] >= 8'd128) ones++;
      l = lfsr_step(l);
    end
    exp_v.push_back(1'b0);
    for (int i = 0; i < 1000; i++) exp_q_b.push_back(32'(i));
    b_start = 1'b1;
    b_len   = 16'd1000;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int c = 0; c < exp_v.size(); c++) begin
      @(negedge clk);
      check("b_valid", b_valid, 32'(exp_v[c]));
      if (c >= 1 && b_busy) begin
        ncyc++;
        if (b_valid) nv++;
      end
    end
    check("b_done", b_done, 32'd1);
    check("b_count", b_cnt, 32'd1000);
    check("b_q_empty", exp_q_b.size(), 32'd0);
    check("b_duty", 32'((nv * 100 >= ncyc * 45) && (nv * 100 <= ncyc * 55)), 32'd1);
  endtask

  initial begin
    int hs;
    int n;
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", a_valid, 32'd0);
    check("rst_data", a_data, 32'd0);
    check("rst_strb", a_strb, 32'd0);
    check("rst_busy", a_busy, 32'd0);
    check("rst_done", a_done, 32'd0);
    check("rst_count", a_cnt, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Four back-to-back beats, two cycles after start
    a_ready = 1'b1;
    start_a(4);
    @(negedge clk);
    check("t1_valid_lat", a_valid, 32'd0);
    check("t1_busy", a_busy, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_valid_run", a_valid, 32'd1);
    end
    @(negedge clk);
    check("t1_valid_end", a_valid, 32'd0);
    check("t1_done", a_done, 32'd1);
    check("t1_count", a_cnt, 32'd4);

    // Backpressure on the first beat
    a_ready = 1'b0;
    start_a(3);
    n = 0;
    while (!a_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_valid_seen", a_valid, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", a_valid, 32'd1);
      check("t2_hold_data", a_data, 32'd0);
      @(negedge clk);
    end
    a_ready = 1'b1;
    wait_done_a(20, 3);

    // Zero-length burst
    start_a(0);
    @(negedge clk);
    check("t3_done", a_done, 32'd1);
    check("t3_busy", a_busy, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t3_no_valid", a_valid, 32'd0);
      @(negedge clk);
    end

    // Reset in the middle of a stalled beat
    start_a(10);
    count_hs_a(5, hs);
    check("t4_hs", hs, 32'd5);
    @(posedge clk); #1 a_ready = 1'b0;
    @(negedge clk);
    check("t4_valid_pre", a_valid, 32'd1);
    check("t4_count_pre", a_cnt, 32'd5);
    check("t4_data_pre", a_data, 32'd5);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_rst_valid", a_valid, 32'd0);
    check("t4_rst_count", a_cnt, 32'd0);
    check("t4_rst_busy", a_busy, 32'd0);
    check("t4_rst_done", a_done, 32'd0);
    exp_q_a.delete();
    rst = 1'b0;
    a_ready = 1'b1;
    start_a(2);
    wait_done_a(20, 2);

    // Enable gap: pending beat is held and taken, no new offer until enable returns
    start_a(8);
    count_hs_a(3, hs);
    @(posedge clk); #1;
    a_en = 1'b0;
    a_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (seen) check("t5_no_offer", a_valid, 32'd0);
      if (a_valid && a_ready) seen = 1'b1;
      @(posedge clk); #1;
      if (i == 2) a_ready = 1'b1;
    end
    check("t5_pending_taken", 32'(seen), 32'd1);
    a_en = 1'b1;
    wait_done_a(50, 8);

    // Random bursts with random ready and enable
    for (int b = 0; b < 6; b++) begin
      int len = $urandom_range(24, 1);
      start_a(len);
      n = 0;
      while (!a_done && n < 400) begin
        a_ready = ($urandom % 4) != 0;
        a_en    = ($urandom % 5) != 0;
        @(posedge clk); #1;
        n++;
      end
      a_en = 1'b1;
      a_ready = 1'b1;
      wait_done_a(20, len);
    end

    // Stalled instance, two runs from the same seed
    run_b();
    run_b();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
